// File: rtl/bayer_pattern_gen.sv
// bayer_pattern_gen: synthetic raw-Bayer frame source with H/V blanking and selectable test patterns.
// Define TPG_NOISE_EN to XOR a per-frame-seeded 16-bit LFSR into the low nibble of each pixel.
module bayer_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 16,
    parameter int V_BLANK  = 64
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic        iSTOP,
    input  logic [1:0]  iMODE,
    input  logic [11:0] iLEVEL,
    output logic [11:0] oDATA,
    output logic        oDVAL,
    output logic [10:0] oX_Cont,
    output logic [10:0] oY_Cont,
    output logic        oFVAL,
    output logic        oBUSY,
    output logic [15:0] oFrame_Cont
);
    typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;
    state_t      state;
    logic [10:0] xCnt, yCnt;
    logic [15:0] blankCnt;
    logic [1:0]  mode;
    logic [11:0] level, pattern, pixel;
    logic        stopPend, lineEnd, lastLine, blankEnd, stopNow, startFrame;
    always_comb begin
        lineEnd    = xCnt == 11'(H_ACTIVE - 1);
        lastLine   = yCnt == 11'(V_ACTIVE - 1);
        blankEnd   = blankCnt == 16'((state == HBLANK) ? H_BLANK - 1 : V_BLANK - 1);
        stopNow    = stopPend || iSTOP;
        startFrame = (state == IDLE && iSTART) || (state == VBLANK && blankEnd && !stopNow);
        pattern    = (mode == 2'd0) ? level :
                     (mode == 2'd1) ? {xCnt, 1'b0} :
                     (mode == 2'd2) ? {yCnt, 1'b0} :
                     (xCnt[0] ^ yCnt[0]) ? (xCnt[0] ? 12'hFFF : 12'h000) : 12'h800;
    end
`ifdef TPG_NOISE_EN
    logic [15:0] lfsr;
    assign pixel = {pattern[11:4], pattern[3:0] ^ lfsr[3:0]};
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST)
            lfsr <= 16'hACE1;
        else if (startFrame)
            lfsr <= 16'hACE1;
        else if (state == ACTIVE)
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
`else
    assign pixel = pattern;
`endif
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state    <= IDLE;
            xCnt     <= '0;
            yCnt     <= '0;
            blankCnt <= '0;
            mode     <= '0;
            level    <= '0;
            stopPend <= 1'b0;
        end else begin
            if (state != IDLE && iSTOP)
                stopPend <= 1'b1;
            if (startFrame) begin
                mode  <= iMODE;
                level <= iLEVEL;
            end
            case (state)
                IDLE: if (iSTART) begin
                    state    <= ACTIVE;
                    stopPend <= iSTOP;
                end
                ACTIVE: if (lineEnd) begin
                    xCnt     <= '0;
                    blankCnt <= '0;
                    state    <= lastLine ? VBLANK : HBLANK;
                    yCnt     <= lastLine ? 11'd0 : yCnt;
                end else begin
                    xCnt <= xCnt + 11'd1;
                end
                HBLANK: if (blankEnd) begin
                    state <= ACTIVE;
                    yCnt  <= yCnt + 11'd1;
                end else begin
                    blankCnt <= blankCnt + 16'd1;
                end
                VBLANK: if (blankEnd) begin
                    state    <= stopNow ? IDLE : ACTIVE;
                    stopPend <= 1'b0;
                end else begin
                    blankCnt <= blankCnt + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // Outputs trail the sequencer by one cycle so every port is a plain register.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oDATA       <= '0;
            oDVAL       <= 1'b0;
            oX_Cont     <= '0;
            oY_Cont     <= '0;
            oFVAL       <= 1'b0;
            oBUSY       <= 1'b0;
            oFrame_Cont <= '0;
        end else begin
            oDATA       <= (state == ACTIVE) ? pixel : 12'h000;
            oDVAL       <= state == ACTIVE;
            oX_Cont     <= xCnt;
            oY_Cont     <= yCnt;
            oFVAL       <= state == ACTIVE || state == HBLANK;
            oBUSY       <= state != IDLE;
            oFrame_Cont <= oFrame_Cont + 16'((oDVAL && oX_Cont == 11'(H_ACTIVE - 1) && oY_Cont == 11'(V_ACTIVE - 1)) ? 1 : 0);
        end
    end
endmodule

// File: tb/tb_bayer_pattern_gen.sv
// tb_bayer_pattern_gen: directed cycle-by-cycle checks of a 4x3 frame with 2-cycle HBLANK and 5-cycle VBLANK.
module tb_bayer_pattern_gen;
    localparam int H = 4, V = 3, HB = 2, VB = 5;
    localparam int L = H + HB;
    localparam int LAST = V * L - HB;
    localparam int PER = V * H + (V - 1) * HB + VB;
    logic        iCLK, iRST, iSTART, iSTOP;
    logic [1:0]  iMODE;
    logic [11:0] iLEVEL, oDATA;
    logic        oDVAL, oFVAL, oBUSY;
    logic [10:0] oX_Cont, oY_Cont;
    logic [15:0] oFrame_Cont;
    int passCnt = 0, totalCnt = 0;
    bayer_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .V_BLANK(VB)) dut (
        .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iSTOP(iSTOP), .iMODE(iMODE), .iLEVEL(iLEVEL),
        .oDATA(oDATA), .oDVAL(oDVAL), .oX_Cont(oX_Cont), .oY_Cont(oY_Cont),
        .oFVAL(oFVAL), .oBUSY(oBUSY), .oFrame_Cont(oFrame_Cont)
    );
    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;
    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask
    function automatic logic [39:0] sig();
        return {3'b0, oBUSY, oFVAL, oDVAL, oX_Cont, oY_Cont, oDATA};
    endfunction
    function automatic logic [11:0] expData(input logic [1:0] m, input logic [11:0] lv, input int x, input int y);
        if (m == 2'd0) return lv;
        if (m == 2'd1) return 12'(x * 2);
        if (m == 2'd2) return 12'(y * 2);
        if (y % 2 == 0) return (x % 2 == 0) ? 12'h800 : 12'hFFF;
        return (x % 2 == 0) ? 12'h000 : 12'h800;
    endfunction
    task automatic checkIdle(input string tag, input logic [15:0] fc);
        chk({tag, "_out"}, sig(), 40'h0);
        chk({tag, "_fc"}, {24'h0, oFrame_Cont}, {24'h0, fc});
    endtask
    task automatic startGen(input string tag, input logic [1:0] m, input logic [11:0] lv, input logic stop);
        iMODE = m; iLEVEL = lv; iSTART = 1'b1; iSTOP = stop;
        @(negedge iCLK);
        iSTART = 1'b0; iSTOP = 1'b0;
        chk({tag, "_lat"}, {39'h0, oDVAL}, 40'h0);
        @(negedge iCLK);
    endtask
    // Called on the negedge showing pixel (0,0); returns on the negedge after the last VBLANK cycle.
    task automatic runFrame(input string tag, input logic [1:0] m, input logic [11:0] lv, input logic [15:0] fc,
                            input int evAt, input logic evStop, input logic evStart,
                            input logic [1:0] nm, input logic [11:0] nl);
        logic [15:0] lf;
        lf = 16'hACE1;
        for (int i = 0; i < PER; i++) begin
            int x, y;
            logic dv, fv;
            logic [11:0] d;
            dv = i < LAST && (i % L) < H;
            fv = i < LAST;
            x = dv ? i % L : 0;
            y = fv ? i / L : 0;
            d = dv ? expData(m, lv, x, y) : 12'h000;
`ifdef TPG_NOISE_EN
            if (dv) begin
                d[3:0] = d[3:0] ^ lf[3:0];
                lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
            end
`endif
            chk($sformatf("%s_c%0d", tag, i), sig(), {3'b0, 1'b1, fv, dv, 11'(x), 11'(y), d});
            if (i == 0) chk({tag, "_fc0"}, {24'h0, oFrame_Cont}, {24'h0, fc});
            if (i == LAST) chk({tag, "_fc1"}, {24'h0, oFrame_Cont}, {24'h0, fc + 16'd1});
            if (i == evAt) begin
                iSTOP = evStop; iSTART = evStart; iMODE = nm; iLEVEL = nl;
            end else begin
                iSTOP = 1'b0; iSTART = 1'b0;
            end
            @(negedge iCLK);
        end
    endtask
    initial begin
        iRST = 1'b0; iSTART = 1'b0; iSTOP = 1'b0; iMODE = 2'd0; iLEVEL = 12'h0;
        repeat (3) @(negedge iCLK);
        checkIdle("rst", 16'd0);
        iRST = 1'b1;
        @(negedge iCLK);
        iSTOP = 1'b1;
        @(negedge iCLK);
        iSTOP = 1'b0;
        repeat (2) @(negedge iCLK);
        checkIdle("stop_idle", 16'd0);
        startGen("f1", 2'd1, 12'h0, 1'b0);
        runFrame("f1", 2'd1, 12'h0, 16'd0, -1, 1'b0, 1'b0, 2'd1, 12'h0);
        runFrame("f2", 2'd1, 12'h0, 16'd1, 3, 1'b1, 1'b1, 2'd1, 12'h0);
        checkIdle("f2_end", 16'd2);
        startGen("f3", 2'd1, 12'h0, 1'b1);
        runFrame("f3", 2'd1, 12'h0, 16'd2, -1, 1'b0, 1'b0, 2'd1, 12'h0);
        checkIdle("f3_end", 16'd3);
        startGen("f4", 2'd3, 12'h0, 1'b0);
        runFrame("f4", 2'd3, 12'h0, 16'd3, 5, 1'b0, 1'b0, 2'd0, 12'h5A5);
        runFrame("f5", 2'd0, 12'h5A5, 16'd4, 2, 1'b1, 1'b0, 2'd0, 12'h5A5);
        checkIdle("f5_end", 16'd5);
        startGen("f6", 2'd2, 12'h0, 1'b0);
        repeat (8) @(negedge iCLK);
        chk("f6_pre", {29'h0, oX_Cont}, 40'd2);
        #2 iRST = 1'b0;
        #1 checkIdle("async_rst", 16'd0);
        @(negedge iCLK);
        iRST = 1'b1;
        @(negedge iCLK);
        checkIdle("post_rst", 16'd0);
        startGen("f7", 2'd2, 12'h0, 1'b1);
        runFrame("f7", 2'd2, 12'h0, 16'd0, -1, 1'b0, 1'b0, 2'd2, 12'h0);
        checkIdle("f7_end", 16'd1);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
